reg_write_queue: RTL
====================

# reg_write_queue

Write-back queue that sits in front of the register block's single write port. It accepts register write requests from execution units over a valid/ready handshake and buffers them in a small in-order FIFO. It retires one write per cycle into the register block. It also provides forwarding lookups on both read ports, so that readers see writes that are still pending in the queue.

## Interface
- DATA_WIDTH, 32, width of register data
- ADDR_WIDTH, 5, width of register identifier
- DEPTH, 4, number of queue entries; power of two, at least 2
- i_Clock  in  1  clock; all state changes on the rising edge
- i_Reset  in  1  reset, asynchronous, active-low
- i_ReqValid  in  1  write request valid
- o_ReqReady  out  1  queue can accept a request this cycle
- i_ReqAddr  in  ADDR_WIDTH  destination register
- i_ReqData  in  DATA_WIDTH  data to write
- o_WrAddr  out  ADDR_WIDTH  register block write address
- o_WrData  out  DATA_WIDTH  register block write data
- o_WrEnable  out  1  register block write enable
- i_RdAddrA  in  ADDR_WIDTH  forwarding lookup address, port A
- o_FwdHitA  out  1  a pending write to i_RdAddrA exists
- o_FwdDataA  out  DATA_WIDTH  data of the youngest pending write to i_RdAddrA
- i_RdAddrB, o_FwdHitB, o_FwdDataB  same as port A, for port B
- o_Count  out  $clog2(DEPTH)+1  number of occupied entries
- o_Empty, o_Full  out  1  occupancy flags

## Operation
- The queue is a circular FIFO with a write pointer, a read pointer and an occupancy counter. Pointers wrap modulo DEPTH.
- Accept: a request is accepted when i_ReqValid and o_ReqReady are both high at a rising edge.
  - o_ReqReady = ~o_Full, with no dependence on i_ReqValid.
  - A push is never accepted while full, even if an entry pops in the same cycle.
- Address 0:
  - A request with i_ReqAddr == 0 is accepted (the handshake completes) and discarded.
  - It is not enqueued and o_Count is unchanged.
- Drain:
  - While not empty, the head entry drives o_WrAddr/o_WrData and o_WrEnable = 1.
  - The head is popped at the next rising edge; the register block writes on that same edge.
  - While empty: o_WrEnable = 0, o_WrAddr = 0, o_WrData = 0.
- Simultaneous push and pop (not full, not empty): both pointers advance and o_Count is unchanged.
- Ordering: writes retire strictly in acceptance order. Two writes to the same register both retire; the later one wins.
- Forwarding, port A (B is identical):
  - Search all occupied entries, including the head being written this cycle, for address == i_RdAddrA.
  - On a match: o_FwdHitA = 1 and o_FwdDataA = data of the youngest matching entry.
  - With no match, or i_RdAddrA == 0: o_FwdHitA = 0 and o_FwdDataA = 0.
  - A request presented in the same cycle, not yet accepted, is never forwarded.
- The consumer selects o_FwdDataX when o_FwdHitX = 1, else the register block read data.

## Timing
- Reset (i_Reset = 0, asynchronous):
  - Pointers and counter clear; entry contents are don't-care.
  - o_ReqReady = 0, o_WrEnable = 0, o_WrAddr = 0, o_WrData = 0.
  - o_FwdHitA/B = 0, o_FwdDataA/B = 0, o_Count = 0, o_Empty = 1, o_Full = 0.
- First cycle after reset release: o_ReqReady = 1.
- Reset asserted mid-operation drops all pending writes immediately, with no partial retire.
- Latency:
  - A request accepted at edge N into an empty queue gives o_WrEnable = 1 during cycle N+1.
  - That write lands in the register block at edge N+1.
  - The entry is forwardable from cycle N+1 until that edge.
- Throughput: one accept and one retire per cycle sustained.
- Flags: o_Empty = (o_Count == 0) and o_Full = (o_Count == DEPTH), both derived from registered state.
- Write and forwarding outputs: combinational from registered state and i_RdAddrA/B; no combinational path from i_ReqValid/Addr/Data.

## Test plan
- Reset, then a single push of (addr 5, data 0xDEADBEEF) at edge 1:
  - Cycle 2: o_WrEnable = 1, o_WrAddr = 5, o_WrData = 0xDEADBEEF; o_FwdHitA = 1 with i_RdAddrA = 5.
  - Cycle 3: o_Empty = 1 and o_FwdHitA = 0.
- Push 4 entries back-to-back (DEPTH = 4) while the register block consumes:
  - o_Full and o_ReqReady behave as specified.
  - Writes retire in order 1, 2, 3, 4.
- Push (7, 0x11), then (7, 0x22) → i_RdAddrB = 7 gives o_FwdDataB = 0x22 until the second entry retires. Retire order is 0x11, then 0x22.
- Push (0, 0xFFFF) → handshake completes, o_Count stays 0, o_WrEnable never asserts, and i_RdAddrA = 0 gives hit 0, data 0.
- Sustained push every cycle for 20 cycles with random addresses 1..31 → o_Count stays at 1 and pointer wrap is verified. A scoreboard matches every retired write against its request.
- Assert i_Reset low with 3 entries queued → outputs go to their reset values immediately without waiting for a clock, and no further writes are issued after release.

Source files
------------

// File: rtl/reg_write_queue.sv
// In-order write-back queue feeding the register block's single write port, with two forwarding lookups.
// Head write is presented the cycle after acceptance; requests are refused only while full, and address 0 is accepted then dropped.
module reg_write_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_ReqValid,
  output logic                    o_ReqReady,
  input  logic [ADDR_WIDTH-1:0]   i_ReqAddr,
  input  logic [DATA_WIDTH-1:0]   i_ReqData,
  output logic [ADDR_WIDTH-1:0]   o_WrAddr,
  output logic [DATA_WIDTH-1:0]   o_WrData,
  output logic                    o_WrEnable,
  input  logic [ADDR_WIDTH-1:0]   i_RdAddrA,
  output logic                    o_FwdHitA,
  output logic [DATA_WIDTH-1:0]   o_FwdDataA,
  input  logic [ADDR_WIDTH-1:0]   i_RdAddrB,
  output logic                    o_FwdHitB,
  output logic [DATA_WIDTH-1:0]   o_FwdDataB,
  output logic [$clog2(DEPTH):0]  o_Count,
  output logic                    o_Empty,
  output logic                    o_Full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == LP_FULL);
  assign w_empty    = (r_count == '0);
  assign w_pop      = ~w_empty;
  // Ready is held low while reset is asserted, independent of the request valid.
  assign o_ReqReady = i_Reset & ~w_full;
  assign w_push     = i_ReqValid & o_ReqReady & (i_ReqAddr != '0);

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: i_ReqAddr, data: i_ReqData};
  end

  always_comb begin
    o_WrEnable = w_pop;
    o_WrAddr   = '0;
    o_WrData   = '0;
    if (w_pop) begin
      o_WrAddr = r_mem[r_rd_ptr].addr;
      o_WrData = r_mem[r_rd_ptr].data;
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  function automatic logic [DATA_WIDTH:0] f_lookup(input logic [ADDR_WIDTH-1:0] a);
    logic [PW-1:0]       w_idx;
    logic [DATA_WIDTH:0] w_res;
    w_res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (a != '0) && (r_mem[w_idx].addr == a))
        w_res = {1'b1, r_mem[w_idx].data};
    end
    return w_res;
  endfunction

  assign {o_FwdHitA, o_FwdDataA} = f_lookup(i_RdAddrA);
  assign {o_FwdHitB, o_FwdDataB} = f_lookup(i_RdAddrB);

  assign o_Count = r_count;
  assign o_Empty = w_empty;
  assign o_Full  = w_full;
endmodule
